// File: rtl/combo_lock.sv
// combo_lock: N-digit combination lock with timeout, fail lockout, auto-relock.
// Define COMBO_LOCK_REPROG_EN to let digits entered while OPEN replace the code.
module combo_lock #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASSWORD = 16'h2151,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int DIGIT_TIMEOUT  = 5000,
  parameter int OPEN_CYCLES    = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic                                clear,
  input  logic                                lock,
  output logic                                admitted,
  output logic                                locked_out,
  output logic                                fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     progress,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       entry
);

  localparam int CW = NUM_DIGITS * DIGIT_W;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int PW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT
  } state_e;

  state_e          state_q;
  logic            admitted_q;
  logic            locked_q;
  logic            fpulse_q;
  logic [FW-1:0]   fails_q;
  logic [PW-1:0]   prog_q;
  logic [CW-1:0]   entry_q;
  logic [31:0]     tmr_q;
  logic [31:0]     tmo_q;
  logic [CW-1:0]   code;

  logic [CW-1:0]   entry_wr;
  logic            last_dig;
  logic            tmo_hit;
  logic            open_hit;
  logic            lock_hit;

`ifdef COMBO_LOCK_REPROG_EN
  logic [CW-1:0]   code_q;
  assign code = code_q;
`else
  assign code = PASSWORD;
`endif

  always_comb begin
    entry_wr = entry_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (prog_q == PW'(i))
        entry_wr[i*DIGIT_W +: DIGIT_W] = digit;
    end
    last_dig = (prog_q == PW'(NUM_DIGITS - 1));
    // idle timeout only applies to a partial entry on a digit-free cycle
    tmo_hit  = (DIGIT_TIMEOUT != 0) && (prog_q != '0) && !digit_valid
            && (tmo_q == 32'(DIGIT_TIMEOUT - 1));
    open_hit = (OPEN_CYCLES != 0) && (tmr_q == 32'(OPEN_CYCLES - 1));
    lock_hit = (tmr_q == 32'(LOCKOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ENTRY;
      admitted_q <= 1'b0;
      locked_q   <= 1'b0;
      fpulse_q   <= 1'b0;
      fails_q    <= '0;
      prog_q     <= '0;
      entry_q    <= '0;
      tmr_q      <= '0;
      tmo_q      <= '0;
`ifdef COMBO_LOCK_REPROG_EN
      code_q     <= PASSWORD;
`endif
    end else begin
      fpulse_q <= 1'b0;
      unique case (state_q)
        S_ENTRY: begin
          if (clear || tmo_hit) begin
            prog_q  <= '0;
            entry_q <= '0;
            tmo_q   <= '0;
          end else if (digit_valid) begin
            entry_q <= entry_wr;
            prog_q  <= prog_q + PW'(1);
            tmo_q   <= '0;
            if (last_dig) state_q <= S_CHECK;
          end else if (prog_q != '0) begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_CHECK: begin
          prog_q  <= '0;
          entry_q <= '0;
          tmr_q   <= '0;
          tmo_q   <= '0;
          if (entry_q == code) begin
            state_q    <= S_OPEN;
            admitted_q <= 1'b1;
            fails_q    <= '0;
          end else begin
            fpulse_q <= 1'b1;
            fails_q  <= fails_q + FW'(1);
            if (fails_q == FW'(MAX_FAILS - 1)) begin
              state_q  <= S_LOCKOUT;
              locked_q <= 1'b1;
            end else begin
              state_q <= S_ENTRY;
            end
          end
        end
        S_OPEN: begin
          if (lock || open_hit) begin
            state_q    <= S_ENTRY;
            admitted_q <= 1'b0;
            tmr_q      <= '0;
            tmo_q      <= '0;
            prog_q     <= '0;
            entry_q    <= '0;
          end else begin
            if (OPEN_CYCLES != 0) tmr_q <= tmr_q + 32'd1;
`ifdef COMBO_LOCK_REPROG_EN
            if (clear || tmo_hit) begin
              prog_q  <= '0;
              entry_q <= '0;
              tmo_q   <= '0;
            end else if (digit_valid) begin
              tmo_q <= '0;
              if (last_dig) begin
                code_q     <= entry_wr;
                state_q    <= S_ENTRY;
                admitted_q <= 1'b0;
                prog_q     <= '0;
                entry_q    <= '0;
              end else begin
                entry_q <= entry_wr;
                prog_q  <= prog_q + PW'(1);
              end
            end else if (prog_q != '0) begin
              tmo_q <= tmo_q + 32'd1;
            end
`endif
          end
        end
        S_LOCKOUT: begin
          if (lock_hit) begin
            state_q  <= S_ENTRY;
            locked_q <= 1'b0;
            fails_q  <= '0;
            tmr_q    <= '0;
          end else begin
            tmr_q <= tmr_q + 32'd1;
          end
        end
      endcase
    end
  end

  assign admitted   = admitted_q;
  assign locked_out = locked_q;
  assign fail_pulse = fpulse_q;
  assign fail_count = fails_q;
  assign progress   = prog_q;
  assign entry      = entry_q;

endmodule

// File: tb/tb_combo_lock.sv
// Directed bench for combo_lock with short timers.
// Reprogramming scenario runs only when COMBO_LOCK_REPROG_EN is defined.
module tb_combo_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        clear = 1'b0;
  logic        lock = 1'b0;
  logic        admitted;
  logic        locked_out;
  logic        fail_pulse;
  logic [1:0]  fail_count;
  logic [2:0]  progress;
  logic [15:0] entry;

  int nvec = 0;
  int nerr = 0;

  combo_lock #(
    .LOCKOUT_CYCLES(20),
    .DIGIT_TIMEOUT (10),
    .OPEN_CYCLES   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_valid(digit_valid),
    .digit      (digit),
    .clear      (clear),
    .lock       (lock),
    .admitted   (admitted),
    .locked_out (locked_out),
    .fail_pulse (fail_pulse),
    .fail_count (fail_count),
    .progress   (progress),
    .entry      (entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic relock();
    lock = 1'b1;
    tick();
    lock = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_adm", 32'(admitted), 0);
    chk("rst_lck", 32'(locked_out), 0);
    chk("rst_fp", 32'(fail_pulse), 0);
    chk("rst_fc", 32'(fail_count), 0);
    chk("rst_prog", 32'(progress), 0);
    chk("rst_ent", 32'(entry), 0);

    // correct code
    send(4'd1);
    chk("ok_p1", 32'(progress), 1);
    chk("ok_e1", 32'(entry), 32'h0001);
    send(4'd5);
    chk("ok_e2", 32'(entry), 32'h0051);
    send(4'd1);
    send(4'd2);
    chk("ok_p4", 32'(progress), 4);
    chk("ok_e4", 32'(entry), 32'h2151);
    chk("ok_adm0", 32'(admitted), 0);
    tick();
    chk("ok_adm1", 32'(admitted), 1);
    chk("ok_fc", 32'(fail_count), 0);
    chk("ok_prog0", 32'(progress), 0);
    relock();
    chk("ok_lock", 32'(admitted), 0);

    // wrong code, no early reject
    enter4(4'd1, 4'd5, 4'd9, 4'd2);
    chk("bad_p4", 32'(progress), 4);
    chk("bad_fp0", 32'(fail_pulse), 0);
    tick();
    chk("bad_fp1", 32'(fail_pulse), 1);
    chk("bad_fc1", 32'(fail_count), 1);
    chk("bad_adm", 32'(admitted), 0);
    tick();
    chk("bad_fp_end", 32'(fail_pulse), 0);

    // two more wrongs -> lockout
    enter4(4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("lo_fc2", 32'(fail_count), 2);
    chk("lo_lck_n", 32'(locked_out), 0);
    enter4(4'd3, 4'd3, 4'd3, 4'd3);
    tick();
    chk("lo_fc3", 32'(fail_count), 3);
    chk("lo_lck0", 32'(locked_out), 1);
    for (int i = 1; i < 20; i++) begin
      digit_valid = (i < 10);
      digit = 4'd1;
      clear = (i == 5);
      tick();
      chk($sformatf("lo_hold%0d", i), 32'(locked_out), 1);
      chk($sformatf("lo_prog%0d", i), 32'(progress), 0);
    end
    digit_valid = 1'b0;
    clear = 1'b0;
    tick();
    chk("lo_end", 32'(locked_out), 0);
    chk("lo_fc0", 32'(fail_count), 0);
    enter4(4'd1, 4'd5, 4'd1, 4'd2);
    tick();
    chk("lo_adm", 32'(admitted), 1);
    relock();

    // inter-digit timeout and clear priority
    send(4'd1);
    send(4'd5);
    chk("to_p2", 32'(progress), 2);
    repeat (9) tick();
    chk("to_p2_hold", 32'(progress), 2);
    tick();
    chk("to_p0", 32'(progress), 0);
    chk("to_e0", 32'(entry), 0);
    chk("to_fc", 32'(fail_count), 0);
    send(4'd1);
    chk("clr_p1", 32'(progress), 1);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd5;
    tick();
    clear = 1'b0;
    digit_valid = 1'b0;
    chk("clr_p0", 32'(progress), 0);
    chk("clr_e0", 32'(entry), 0);

    // wrong, wrong, right resets the fail counter
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    tick();
    enter4(4'd8, 4'd8, 4'd8, 4'd8);
    tick();
    chk("wwr_fc2", 32'(fail_count), 2);
    enter4(4'd1, 4'd5, 4'd1, 4'd2);
    tick();
    chk("wwr_adm", 32'(admitted), 1);
    chk("wwr_fc0", 32'(fail_count), 0);
    relock();
    enter4(4'd2, 4'd1, 4'd5, 4'd1);
    tick();
    chk("wwr_fc1", 32'(fail_count), 1);
    chk("wwr_lck", 32'(locked_out), 0);

`ifdef COMBO_LOCK_REPROG_EN
    enter4(4'd1, 4'd5, 4'd1, 4'd2);
    tick();
    chk("rp_open", 32'(admitted), 1);
    enter4(4'd7, 4'd7, 4'd7, 4'd7);
    chk("rp_relock", 32'(admitted), 0);
    enter4(4'd1, 4'd5, 4'd1, 4'd2);
    tick();
    chk("rp_old_fp", 32'(fail_pulse), 1);
    chk("rp_old_adm", 32'(admitted), 0);
    enter4(4'd7, 4'd7, 4'd7, 4'd7);
    tick();
    chk("rp_new_adm", 32'(admitted), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_rst_adm", 32'(admitted), 0);
    enter4(4'd1, 4'd5, 4'd1, 4'd2);
    tick();
    chk("rp_rst_code", 32'(admitted), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
